// File: rtl/csub_sched.sv
// Round-robin scheduler sharing one two-stage complex subtractor between NREQ requesters.
// Optional feature macro: CSUB_SCHED_SAT_EN (result clamping plus sticky sat_flag output).
module csub_sched #(
   parameter int NREQ   = 4,
   parameter int SIZEIN = 16,
   parameter int IDW    = $clog2(NREQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [NREQ*SIZEIN-1:0] req_ar,
   input  logic [NREQ*SIZEIN-1:0] req_ai,
   input  logic [NREQ*SIZEIN-1:0] req_br,
   input  logic [NREQ*SIZEIN-1:0] req_bi,
   output logic                   csub_ce,
   output logic [SIZEIN-1:0]      csub_ar,
   output logic [SIZEIN-1:0]      csub_ai,
   output logic [SIZEIN-1:0]      csub_br,
   output logic [SIZEIN-1:0]      csub_bi,
   input  logic [SIZEIN:0]        csub_sr,
   input  logic [SIZEIN:0]        csub_si,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [IDW-1:0]         res_id,
   output logic [SIZEIN:0]        res_sr,
   output logic [SIZEIN:0]        res_si,
   output logic                   busy
`ifdef CSUB_SCHED_SAT_EN
   ,
   output logic                   sat_flag
`endif
);

   logic [1:0]     v_q, v_d;
   logic [IDW-1:0] id0_q, id0_d;
   logic [IDW-1:0] id1_q, id1_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

   logic           grant_any;
   logic [IDW-1:0] grant_id;
   logic [NREQ-1:0] grant_oh;

   // A result waiting on a stalled consumer freezes the whole subtractor pipeline.
   assign csub_ce = !(v_q[1] && !res_ready);

   always_comb begin
      logic [IDW:0]   cand;
      logic [IDW-1:0] cand_id;
      cand      = '0;
      cand_id   = '0;
      grant_any = 1'b0;
      grant_id  = '0;
      grant_oh  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) begin
            cand = cand - (IDW+1)'(NREQ);
         end
         cand_id = cand[IDW-1:0];
         if (csub_ce && !grant_any && req_valid[cand_id]) begin
            grant_any         = 1'b1;
            grant_id          = cand_id;
            grant_oh[cand_id] = 1'b1;
         end
      end
   end

   assign req_ready = grant_oh;

   // grant_id is zero without a grant, so idle cycles present requester 0's operands.
   always_comb begin
      csub_ar = req_ar[SIZEIN-1:0];
      csub_ai = req_ai[SIZEIN-1:0];
      csub_br = req_br[SIZEIN-1:0];
      csub_bi = req_bi[SIZEIN-1:0];
      for (int i = 1; i < NREQ; i++) begin
         if (grant_id == IDW'(i)) begin
            csub_ar = req_ar[i*SIZEIN +: SIZEIN];
            csub_ai = req_ai[i*SIZEIN +: SIZEIN];
            csub_br = req_br[i*SIZEIN +: SIZEIN];
            csub_bi = req_bi[i*SIZEIN +: SIZEIN];
         end
      end
   end

   always_comb begin
      v_d      = v_q;
      id0_d    = id0_q;
      id1_d    = id1_q;
      rr_ptr_d = rr_ptr_q;
      if (csub_ce) begin
         v_d   = {v_q[0], grant_any};
         id0_d = grant_id;
         id1_d = id0_q;
      end
      if (grant_any) begin
         rr_ptr_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q      <= '0;
         id0_q    <= '0;
         id1_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         v_q      <= v_d;
         id0_q    <= id0_d;
         id1_q    <= id1_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign res_valid = v_q[1];
   assign res_id    = id1_q;
   assign busy      = |v_q;

`ifdef CSUB_SCHED_SAT_EN
   localparam logic [SIZEIN:0] SAT_MAX = {2'b00, {(SIZEIN-1){1'b1}}};
   localparam logic [SIZEIN:0] SAT_MIN = {2'b11, {(SIZEIN-1){1'b0}}};

   logic ovf_r, ovf_i;
   logic sat_flag_q, sat_flag_d;

   // Out of SIZEIN signed range exactly when the two top bits disagree.
   assign ovf_r = csub_sr[SIZEIN] ^ csub_sr[SIZEIN-1];
   assign ovf_i = csub_si[SIZEIN] ^ csub_si[SIZEIN-1];

   always_comb begin
      res_sr     = csub_sr;
      res_si     = csub_si;
      sat_flag_d = sat_flag_q;
      if (ovf_r) begin
         res_sr = csub_sr[SIZEIN] ? SAT_MIN : SAT_MAX;
      end
      if (ovf_i) begin
         res_si = csub_si[SIZEIN] ? SAT_MIN : SAT_MAX;
      end
      if (v_q[1] && res_ready && (ovf_r || ovf_i)) begin
         sat_flag_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_flag_q <= 1'b0;
      end else begin
         sat_flag_q <= sat_flag_d;
      end
   end

   assign sat_flag = sat_flag_q;
`else
   assign res_sr = csub_sr;
   assign res_si = csub_si;
`endif

endmodule

// File: tb/tb_csub_sched.sv
// Self-checking bench for csub_sched: external subtractor model, queue-based reference model
// compared every cycle, and directed scenarios with hand-computed expectations.
module tb_csub_sched;
   localparam int NREQ   = 4;
   localparam int SIZEIN = 16;
   localparam int IDW    = 2;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*SIZEIN-1:0] req_ar, req_ai, req_br, req_bi;
   logic                   csub_ce;
   logic [SIZEIN-1:0]      csub_ar, csub_ai, csub_br, csub_bi;
   logic [SIZEIN:0]        csub_sr, csub_si;
   logic                   res_valid;
   logic                   res_ready;
   logic [IDW-1:0]         res_id;
   logic [SIZEIN:0]        res_sr, res_si;
   logic                   busy;
`ifdef CSUB_SCHED_SAT_EN
   logic                   sat_flag;
`endif

   csub_sched #(.NREQ(NREQ), .SIZEIN(SIZEIN), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_ar(req_ar), .req_ai(req_ai), .req_br(req_br), .req_bi(req_bi),
      .csub_ce(csub_ce),
      .csub_ar(csub_ar), .csub_ai(csub_ai), .csub_br(csub_br), .csub_bi(csub_bi),
      .csub_sr(csub_sr), .csub_si(csub_si),
      .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
      .res_sr(res_sr), .res_si(res_si), .busy(busy)
`ifdef CSUB_SCHED_SAT_EN
      , .sat_flag(sat_flag)
`endif
   );

   always #5 clk = ~clk;

   // External two-stage subtractor, advancing only on clock-enabled edges.
   logic [SIZEIN:0] s1_r = '0, s1_i = '0, s2_r = '0, s2_i = '0;
   always @(posedge clk) begin
      if (csub_ce) begin
         s1_r <= {csub_ar[SIZEIN-1], csub_ar} - {csub_br[SIZEIN-1], csub_br};
         s1_i <= {csub_ai[SIZEIN-1], csub_ai} - {csub_bi[SIZEIN-1], csub_bi};
         s2_r <= s1_r;
         s2_i <= s1_i;
      end
   end
   assign csub_sr = s2_r;
   assign csub_si = s2_i;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic check_output(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Requester-side stimulus state.
   logic [SIZEIN-1:0] op_ar [NREQ];
   logic [SIZEIN-1:0] op_ai [NREQ];
   logic [SIZEIN-1:0] op_br [NREQ];
   logic [SIZEIN-1:0] op_bi [NREQ];
   int                cnt   [NREQ];

   task automatic apply_stimulus();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i] = (cnt[i] > 0);
         req_ar[i*SIZEIN +: SIZEIN] = op_ar[i];
         req_ai[i*SIZEIN +: SIZEIN] = op_ai[i];
         req_br[i*SIZEIN +: SIZEIN] = op_br[i];
         req_bi[i*SIZEIN +: SIZEIN] = op_bi[i];
      end
   endtask

   // Reference model: queue of in-flight operations with their clock-enabled age.
   typedef struct { int id; int sr; int si; bit clp; int age; } op_t;
   typedef struct { int id; logic [SIZEIN:0] raw_sr; int sr; int si; int cyc; } res_t;
   typedef struct { int id; int cyc; } gnt_t;
   op_t  mq[$];
   res_t res_log[$];
   gnt_t gnt_log[$];
   int   m_ptr = 0;
   bit   m_sat = 1'b0;

   function automatic int clamp(input int d);
`ifdef CSUB_SCHED_SAT_EN
      if (d > 32767)  return 32767;
      if (d < -32768) return -32768;
`endif
      return d;
   endfunction

   function automatic bit out_of_range(input int d);
      return (d > 32767) || (d < -32768);
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mq.delete();
            m_ptr = 0;
            m_sat = 1'b0;
         end else begin
            bit fv, e_ce;
            int g, sel, dr, di;
            logic [NREQ-1:0] e_ready;
            op_t n;
            fv   = (mq.size() > 0) && (mq[0].age >= 2);
            e_ce = !(fv && !res_ready);
            g    = -1;
            if (e_ce) begin
               for (int k = 0; k < NREQ; k++) begin
                  int idx;
                  idx = (m_ptr + k) % NREQ;
                  if (g < 0 && req_valid[idx]) g = idx;
               end
            end
            e_ready = '0;
            if (g >= 0) e_ready[g] = 1'b1;
            sel = (g >= 0) ? g : 0;
            check_output("csub_ce", csub_ce, e_ce);
            check_output("req_ready", req_ready, e_ready);
            check_output("res_valid", res_valid, fv);
            check_output("busy", busy, mq.size() > 0);
            check_output("csub_ar", csub_ar, op_ar[sel]);
            check_output("csub_ai", csub_ai, op_ai[sel]);
            check_output("csub_br", csub_br, op_br[sel]);
            check_output("csub_bi", csub_bi, op_bi[sel]);
            if (fv) begin
               check_output("res_id", res_id, mq[0].id);
               check_output("res_sr", int'($signed(res_sr)), mq[0].sr);
               check_output("res_si", int'($signed(res_si)), mq[0].si);
            end
`ifdef CSUB_SCHED_SAT_EN
            check_output("sat_flag", sat_flag, m_sat);
`endif
            for (int i = 0; i < NREQ; i++) begin
               if (req_valid[i] && req_ready[i]) gnt_log.push_back('{id: i, cyc: cyc});
            end
            if (res_valid && res_ready) begin
               res_log.push_back('{id: int'(res_id), raw_sr: res_sr, sr: int'($signed(res_sr)),
                                   si: int'($signed(res_si)), cyc: cyc});
            end
            if (e_ce) begin
               if (fv) begin
                  if (mq[0].clp) m_sat = 1'b1;
                  void'(mq.pop_front());
               end
               foreach (mq[j]) mq[j].age++;
               if (g >= 0) begin
                  dr = int'($signed(op_ar[g])) - int'($signed(op_br[g]));
                  di = int'($signed(op_ai[g])) - int'($signed(op_bi[g]));
                  n.id  = g;
                  n.sr  = clamp(dr);
                  n.si  = clamp(di);
                  n.clp = out_of_range(dr) || out_of_range(di);
                  n.age = 1;
                  mq.push_back(n);
                  m_ptr = (g + 1) % NREQ;
               end
            end
         end
         cyc++;
      end
   end

   // Requesters drop a request once accepted and present fresh operands for the next one.
   task automatic run_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         logic [NREQ-1:0] acc;
         @(negedge clk);
         acc = rst_n ? (req_valid & req_ready) : '0;
         @(posedge clk);
         #1;
         for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
               cnt[i]--;
               op_ar[i] += 16'd7;
               op_ai[i] -= 16'd3;
               op_br[i] += 16'd1;
               op_bi[i] += 16'd11;
            end
         end
         apply_stimulus();
      end
   endtask

   task automatic clear_logs();
      res_log.delete();
      gnt_log.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      for (int i = 0; i < NREQ; i++) cnt[i] = 0;
      apply_stimulus();
      res_ready = 1'b1;
      #1;
      check_output("rst_res_valid", res_valid, 0);
      check_output("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_logs();
   endtask

   initial begin
      bit found;
      logic [SIZEIN:0] held;
      res_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         cnt[i] = 0; op_ar[i] = '0; op_ai[i] = '0; op_br[i] = '0; op_bi[i] = '0;
      end
      apply_stimulus();

      // Reset state
      #3;
      check_output("reset_res_valid", res_valid, 0);
      check_output("reset_res_id", res_id, 0);
      check_output("reset_busy", busy, 0);
      check_output("reset_csub_ce", csub_ce, 1);
      check_output("reset_req_ready_idle", req_ready, 0);
      cnt[1] = 1; cnt[2] = 1;
      apply_stimulus();
      #1;
      check_output("reset_req_ready_grant", req_ready, 4'b0010);
      cnt[1] = 0; cnt[2] = 0;
      apply_stimulus();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_logs();

      // Single request from req0
      op_ar[0] = 16'd100; op_ai[0] = 16'hFFFB; op_br[0] = 16'd30; op_bi[0] = 16'd20;
      cnt[0] = 1;
      apply_stimulus();
      run_cycles(6);
      check_output("single_count", res_log.size(), 1);
      if (res_log.size() == 1 && gnt_log.size() == 1) begin
         check_output("single_id", res_log[0].id, 0);
         check_output("single_sr", res_log[0].sr, 70);
         check_output("single_si", res_log[0].si, -25);
         check_output("single_latency", res_log[0].cyc - gnt_log[0].cyc, 2);
      end

      // Round robin over all four requesters
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         op_ar[i] = 16'(100 * (i + 1)); op_ai[i] = 16'(-10 * i);
         op_br[i] = 16'(7 * i);         op_bi[i] = 16'd3;
         cnt[i] = 3;
      end
      apply_stimulus();
      run_cycles(20);
      check_output("rr_grant_count", gnt_log.size(), 12);
      check_output("rr_result_count", res_log.size(), 12);
      if (gnt_log.size() == 12 && res_log.size() == 12) begin
         for (int k = 0; k < 12; k++) begin
            check_output("rr_grant_order", gnt_log[k].id, k % 4);
            check_output("rr_result_order", res_log[k].id, k % 4);
            if (k > 0) check_output("rr_back_to_back", res_log[k].cyc - res_log[k-1].cyc, 1);
         end
      end

      // Backpressure on a req2 stream
      do_reset();
      op_ar[2] = 16'd1000; op_ai[2] = 16'd50; op_br[2] = 16'd10; op_bi[2] = 16'hFFCE;
      cnt[2] = 6;
      apply_stimulus();
      found = 1'b0;
      for (int w = 0; w < 20 && !found; w++) begin
         run_cycles(1);
         if (res_valid) found = 1'b1;
      end
      check_output("bp_first_result_seen", found, 1);
      run_cycles(1);
      res_ready = 1'b0;
      #1;
      held = res_sr;
      for (int s = 0; s < 5; s++) begin
         check_output("bp_ce_low", csub_ce, 0);
         check_output("bp_ready_low", req_ready, 0);
         check_output("bp_valid_held", res_valid, 1);
         check_output("bp_sr_held", res_sr, held);
         if (s < 4) run_cycles(1);
      end
      res_ready = 1'b1;
      run_cycles(15);
      check_output("bp_result_count", res_log.size(), 6);
      if (res_log.size() == 6) begin
         for (int k = 0; k < 6; k++) begin
            check_output("bp_sr_seq", res_log[k].sr, 990 + 6 * k);
            check_output("bp_si_seq", res_log[k].si, 100 - 14 * k);
         end
      end

      // Pointer skip: move pointer to 2, then only req1 and req3 request
      do_reset();
      cnt[1] = 1;
      apply_stimulus();
      run_cycles(4);
      clear_logs();
      cnt[1] = 1; cnt[3] = 1;
      apply_stimulus();
      run_cycles(4);
      check_output("skip_grant_count", gnt_log.size(), 2);
      if (gnt_log.size() == 2) begin
         check_output("skip_first", gnt_log[0].id, 3);
         check_output("skip_second", gnt_log[1].id, 1);
      end
      clear_logs();
      for (int i = 0; i < NREQ; i++) cnt[i] = 1;
      apply_stimulus();
      run_cycles(1);
      check_output("skip_ptr_after", (gnt_log.size() > 0) ? gnt_log[0].id : -1, 2);
      run_cycles(8);

      // Asynchronous reset with two results in flight
      do_reset();
      op_ar[0] = 16'd500; op_ai[0] = 16'd1; op_br[0] = 16'd2; op_bi[0] = 16'd3;
      cnt[0] = 2;
      apply_stimulus();
      run_cycles(2);
      check_output("inflight_busy", busy, 1);
      check_output("inflight_valid", res_valid, 1);
      #1;
      rst_n = 1'b0;
      cnt[0] = 0;
      apply_stimulus();
      #1;
      check_output("async_rst_valid", res_valid, 0);
      check_output("async_rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_logs();
      run_cycles(5);
      check_output("no_stale_results", res_log.size(), 0);
      op_ar[0] = 16'd5; op_ai[0] = 16'd9; op_br[0] = 16'd3; op_bi[0] = 16'd4;
      cnt[0] = 1;
      apply_stimulus();
      run_cycles(6);
      check_output("post_rst_count", res_log.size(), 1);
      if (res_log.size() == 1) begin
         check_output("post_rst_id", res_log[0].id, 0);
         check_output("post_rst_sr", res_log[0].sr, 2);
         check_output("post_rst_si", res_log[0].si, 5);
      end

      // Full-scale difference: clamped or passed through at 17 bits
      do_reset();
`ifdef CSUB_SCHED_SAT_EN
      check_output("sat_flag_clear", sat_flag, 0);
`endif
      op_ar[0] = 16'h7FFF; op_br[0] = 16'h8000; op_ai[0] = 16'h8000; op_bi[0] = 16'd1;
      cnt[0] = 1;
      apply_stimulus();
      run_cycles(6);
      check_output("sat_count", res_log.size(), 1);
      if (res_log.size() == 1) begin
`ifdef CSUB_SCHED_SAT_EN
         check_output("sat_sr_raw", res_log[0].raw_sr, 32767);
         check_output("sat_si", res_log[0].si, -32768);
         check_output("sat_flag_set", sat_flag, 1);
`else
         check_output("sat_sr_raw", res_log[0].raw_sr, 65535);
         check_output("sat_si", res_log[0].si, -32769);
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
